// File: rtl/alu_iter.sv
// Registered, handshaked RV32 execute unit: single-cycle integer ALU ops plus optional
// iterative (1 bit/cycle) multiply/divide. One operation in flight at a time.
module alu_iter #(
  parameter int unsigned XLEN = 32,
  parameter bit          EN_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [ShW-1:0]      count_q, count_d;
  // Mul: {partial product, multiplier}; Div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic                neg_q, neg_d;
  logic                sel_q, sel_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;
  logic                illegal_q, illegal_d;

  logic            accept, last;
  logic            is_m, m_legal, m_is_div;
  logic [3:0]      ctl;
  logic [XLEN-1:0] base_res;
  logic            base_legal;
  logic            div_b0, div_ovf, quick;
  logic [XLEN-1:0] quick_res;
  logic            quick_ill;
  logic            sa, sb, an, bn;
  logic [XLEN-1:0] a_mag, b_mag;

  assign is_m     = op[4];
  assign ctl      = op[3:0];
  assign m_legal  = EN_M & ~ctl[3];
  assign m_is_div = ctl[2];
  assign accept   = in_valid & in_ready;
  assign last     = (count_q == ShW'(XLEN - 1));

  always_comb begin
    base_res   = '0;
    base_legal = 1'b1;
    case (ctl)
      4'b0000: base_res = a & b;
      4'b0001: base_res = a | b;
      4'b0010: base_res = a + b;
      4'b0110: base_res = a - b;
      4'b0011: base_res = a ^ b;
      4'b0100: base_res = a << b[ShW-1:0];
      4'b0101: base_res = a >> b[ShW-1:0];
      4'b0111: base_res = $unsigned($signed(a) >>> b[ShW-1:0]);
      4'b1000: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'b1001: base_res = {{(XLEN-1){1'b0}}, a < b};
      default: base_legal = 1'b0;
    endcase
  end

  // Division corner cases are resolved at accept and never enter the iterative path
  assign div_b0  = (b == '0);
  assign div_ovf = ~ctl[0] & (a == MinNeg) & (&b);
  assign quick   = ~is_m | ~m_legal | (m_is_div & (div_b0 | div_ovf));

  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    if (!is_m) begin
      quick_res = base_legal ? base_res : '0;
      quick_ill = ~base_legal;
    end else if (!m_legal) begin
      quick_ill = 1'b1;
    end else if (div_b0) begin
      quick_res = ctl[1] ? a : '1;
    end else begin
      quick_res = ctl[1] ? '0 : a;
    end
  end

  assign sa    = m_is_div ? ~ctl[0] : (ctl[1] ^ ctl[0]);
  assign sb    = m_is_div ? ~ctl[0] : (ctl[1:0] == 2'b01);
  assign an    = sa & a[XLEN-1];
  assign bn    = sb & b[XLEN-1];
  assign a_mag = an ? -a : a;
  assign b_mag = bn ? -b : b;

  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_next, div_next, mul_signed;
  logic [XLEN-1:0]   mul_fin, div_mag, div_fin, iter_res;

  assign mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next   = {mul_sum, prod_q[XLEN-1:1]};
  assign mul_signed = neg_q ? -mul_next : mul_next;
  assign mul_fin    = sel_q ? mul_signed[2*XLEN-1:XLEN] : mul_signed[XLEN-1:0];

  assign div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, opnd_q};
  assign div_ge    = ~div_trial[XLEN];
  assign div_next  = {(div_ge ? div_trial[XLEN-1:0] : prod_q[2*XLEN-2:XLEN-1]),
                      prod_q[XLEN-2:0], div_ge};
  assign div_mag   = sel_q ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
  assign div_fin   = neg_q ? -div_mag : div_mag;

  assign iter_res  = (state_q == StMul) ? mul_fin : div_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      prod_q    <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      sel_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prod_q    <= prod_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      sel_q     <= sel_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = quick ? StDone : (m_is_div ? StDiv : StMul);
        end else if ((state_q == StDone) && out_ready) begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: if (last) state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    count_d   = count_q;
    prod_d    = prod_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    sel_d     = sel_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (!flush) begin
      if (accept) begin
        count_d = '0;
        if (quick) begin
          result_d  = quick_res;
          zero_d    = (quick_res == '0);
          illegal_d = quick_ill;
        end else begin
          prod_d = {{XLEN{1'b0}}, (m_is_div ? a_mag : b_mag)};
          opnd_d = m_is_div ? b_mag : a_mag;
          neg_d  = (m_is_div & ctl[1]) ? an : (an ^ bn);
          sel_d  = m_is_div ? ctl[1] : (ctl[1:0] != 2'b00);
        end
      end else if ((state_q == StMul) || (state_q == StDiv)) begin
        count_d = count_q + 1'b1;
        prod_d  = (state_q == StMul) ? mul_next : div_next;
        if (last) begin
          result_d  = iter_res;
          zero_d    = (iter_res == '0);
          illegal_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_valid = (state_q == StDone);
    in_ready  = ~flush & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule
